delay_line_ctrl: RTL and testbench

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

---
 rtl/delay_line_ctrl_pkg.sv | 15 +
 rtl/delay_stage.sv | 20 ++
 rtl/delay_line_ctrl.sv | 114 +++++++++++
 tb/tb_delay_line_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/delay_line_ctrl_pkg.sv
// Shared constants for the programmable delay line: default sizing and
// the two-state FSM encoding used by delay_line_ctrl.
package delay_line_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 32;

    typedef logic [0:0] state_t;

    // RUN: output qualified, new configuration accepted.
    // FILL: tap just changed (or reset), output suppressed until it settles.
    localparam state_t ST_RUN  = 1'b0;
    localparam state_t ST_FILL = 1'b1;

endpackage

// File: rtl/delay_stage.sv
// One register stage of the delay line: W-bit flop with synchronous clear.
module delay_stage #(
    parameter int W = 17
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Shift one step per cycle; reset clears the stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Programmable delay line: DEPTH shift stages of {valid, data}, a registered
// tap mux selecting stage[delay_o], and a RUN/FILL FSM that suppresses
// valid_o for delay_o+2 cycles after every tap change or reset.
module delay_line_ctrl
    import delay_line_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int DW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic [DW-1:0]    cfg_delay_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [DW-1:0]    delay_o,
    output logic             busy_o
);

    localparam logic [DW:0] CNT_ONE = 1;

    // Stage array: bit WIDTH is the valid tag, lower bits are the sample.
    logic [WIDTH:0] stage_q [DEPTH];

    state_t         state_reg, state_next;
    logic [DW-1:0]  delay_reg, delay_next;
    // One bit wider than the tap index so the terminal value delay+1 never
    // wraps, even at the deepest tap.
    logic [DW:0]    cnt_reg, cnt_next;
    logic [DW:0]    fill_last;
    logic [WIDTH:0] tap;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                delay_stage #(.W(WIDTH + 1)) u_stage (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .d_i   ({valid_i, data_i}),
                    .q_o   (stage_q[gi])
                );
            end else begin : g_body
                delay_stage #(.W(WIDTH + 1)) u_stage (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .d_i   (stage_q[gi-1]),
                    .q_o   (stage_q[gi])
                );
            end
        end
    endgenerate

    assign tap       = stage_q[delay_reg];
    assign fill_last = {1'b0, delay_reg} + CNT_ONE;

    // Next-state logic: accept a request only in RUN; FILL counts to delay+1.
    always_comb begin
        state_next = state_reg;
        delay_next = delay_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_RUN) begin
            if (cfg_valid_i) begin
                state_next = ST_FILL;
                delay_next = cfg_delay_i;
                cnt_next   = '0;
            end
        end else begin
            cnt_next = cnt_reg + CNT_ONE;
            if (cnt_reg == fill_last) begin
                state_next = ST_RUN;
            end
        end
    end

    // FSM, active tap and fill counter; reset restarts a delay-0 fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_FILL;
            delay_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            delay_reg <= delay_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Registered tap output; stage contents are never flushed on reconfig.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            data_reg  <= tap[WIDTH-1:0];
            valid_reg <= tap[WIDTH];
        end
    end

    assign data_o      = data_reg;
    // Masking by the registered state lets the acceptance cycle still show
    // the old tap while every FILL cycle reads as invalid.
    assign valid_o     = valid_reg & (state_reg == ST_RUN);
    assign delay_o     = delay_reg;
    assign cfg_ready_o = (state_reg == ST_RUN);
    assign busy_o      = (state_reg == ST_FILL);

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl: reset, latency, reconfiguration,
// deepest tap, request during FILL and reset during FILL.
module tb_delay_line_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int DW    = 5;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic [DW-1:0]    cfg_delay_i;
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic [DW-1:0]    delay_o;
    logic             busy_o;

    int n_cmp = 0;
    int n_err = 0;

    delay_line_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .cfg_delay_i (cfg_delay_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .delay_o     (delay_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d);
        valid_i = v;
        data_i  = d;
    endtask

    task automatic configure(input logic [DW-1:0] d);
        cfg_valid_i = 1'b1;
        cfg_delay_i = d;
        tick();
        cfg_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; data_i = '0; valid_i = 1'b0;
        cfg_delay_i = '0; cfg_valid_i = 1'b0;

        // Reset held for 3 cycles, then a 2-cycle delay-0 FILL.
        drive(1'b1, 16'h1111);
        repeat (3) tick();
        check("rst_data", data_o, 0);
        check("rst_valid", valid_o, 0);
        rst_i = 1'b0;
        drive(1'b0, 16'h0000);
        check("rst_busy0", busy_o, 1);
        check("rst_ready0", cfg_ready_o, 0);
        tick();
        check("rst_busy1", busy_o, 1);
        check("rst_valid1", valid_o, 0);
        tick();
        check("rst_busy2", busy_o, 0);
        check("rst_ready2", cfg_ready_o, 1);
        check("rst_delay", delay_o, 0);

        // Delay 0 latency: data appears 2 cycles after it is driven.
        drive(1'b1, 16'd1); tick();
        drive(1'b1, 16'd2); tick();
        check("lat0_d1", data_o, 1);
        check("lat0_v1", valid_o, 1);
        drive(1'b1, 16'd3); tick();
        check("lat0_d2", data_o, 2);
        drive(1'b0, 16'd0); tick();
        check("lat0_d3", data_o, 3);
        check("lat0_v3", valid_o, 1);

        // Reconfigure to 5: old tap visible on acceptance, FILL for 7 cycles.
        drive(1'b0, 16'd0); tick();
        cfg_valid_i = 1'b1; cfg_delay_i = 5;
        check("acc_ready", cfg_ready_o, 1);
        tick();
        cfg_valid_i = 1'b0;
        check("acc_delay", delay_o, 5);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("fill5_busy%0d", i), busy_o, 1);
            check($sformatf("fill5_valid%0d", i), valid_o, 0);
            tick();
        end
        check("fill5_done", busy_o, 0);
        check("fill5_ready", cfg_ready_o, 1);
        drive(1'b1, 16'hABCD); tick();
        drive(1'b0, 16'h0000);
        repeat (5) tick();
        check("lat5_early", data_o, 0);
        tick();
        check("lat5_data", data_o, 16'hABCD);
        check("lat5_valid", valid_o, 1);

        // Same delay again still runs a full FILL.
        configure(5);
        repeat (6) tick();
        check("same_busy", busy_o, 1);
        tick();
        check("same_done", busy_o, 0);

        // Deepest tap: FILL 33 cycles, latency 33 cycles, no counter wrap.
        configure(31);
        check("max_delay", delay_o, 31);
        repeat (32) tick();
        check("max_busy32", busy_o, 1);
        tick();
        check("max_busy33", busy_o, 0);
        drive(1'b1, 16'h5A5A); tick();
        drive(1'b0, 16'h0000);
        repeat (31) tick();
        check("lat31_early", data_o, 0);
        tick();
        check("lat31_data", data_o, 16'h5A5A);
        check("lat31_valid", valid_o, 1);

        // Request held during FILL is ignored until RUN, then accepted.
        configure(5);
        cfg_valid_i = 1'b1; cfg_delay_i = 7;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("hold_delay%0d", i), delay_o, 5);
            check($sformatf("hold_ready%0d", i), cfg_ready_o, 0);
            tick();
        end
        check("hold_run_ready", cfg_ready_o, 1);
        tick();
        cfg_valid_i = 1'b0;
        check("hold_acc_delay", delay_o, 7);
        check("hold_acc_busy", busy_o, 1);
        repeat (8) tick();
        check("hold_busy8", busy_o, 1);
        tick();
        check("hold_busy9", busy_o, 0);

        // Reset at FILL cycle 3 wins: tap back to 0, 2-cycle FILL restarts.
        drive(1'b1, 16'h7777);
        configure(5);
        repeat (3) tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        drive(1'b0, 16'h0000);
        check("mrst_delay", delay_o, 0);
        check("mrst_data", data_o, 0);
        check("mrst_busy", busy_o, 1);
        tick();
        check("mrst_data1", data_o, 0);
        check("mrst_busy1", busy_o, 1);
        tick();
        check("mrst_run", busy_o, 0);

        // Reset concurrent with a request discards the request.
        cfg_valid_i = 1'b1; cfg_delay_i = 9; rst_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0; rst_i = 1'b0;
        check("crst_delay", delay_o, 0);
        check("crst_busy", busy_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
